sevenseg_text_writer: RTL and testbench

SEVENSEG_TEXT_WRITER -- requirements
Module: sevenseg_text_writer

---
 rtl/sevenseg_text_writer_if.sv | 19 +
 rtl/sevenseg_text_writer.sv | 143 ++++++++++++++
 tb/tb_sevenseg_text_writer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_text_writer_if.sv
// Character handshake between an upstream text source and the seven-segment text writer.
// The master presents ASCII codes; the slave signals when it can take one.
interface sevenseg_text_writer_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_data,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        output char_ready
    );
endinterface

// File: rtl/sevenseg_text_writer.sv
// Four-slot scrolling text buffer for a seven-segment display driver.
// Characters shift in from the right; a newline blanks the buffer; each accepted character is followed by a hold period.
module sevenseg_text_writer #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                  system1000,
    input  logic                  system1000_rstn,
    sevenseg_text_writer_if.slave ch,
    input  logic                  clear,
    output logic [127:0]          outputs_o,
    output logic [2:0]            char_count,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam bit          HOLD_EN   = (HOLD_CYCLES != 0);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]  NEWLINE   = 8'h0A;
    localparam logic [2:0]  COUNT_MAX = 3'd4;

    state_t      state_r;
    logic [15:0] hold_cnt_r;
    logic        busy_r;
    logic [7:0]  slot_r [4];
    logic [2:0]  count_r;

    logic        ready_s;
    logic        xfer_s;
    logic        newline_s;

    // A slot carries the character code in its low byte; code 0 shows as blank.
    function automatic logic [31:0] pack_slot(input logic [7:0] code);
        return {24'd0, code};
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        logic [2:0] res;
        if (cnt >= COUNT_MAX) begin
            res = COUNT_MAX;
        end else begin
            res = cnt + 3'd1;
        end
        return res;
    endfunction

    // Handshake decode: only IDLE accepts, and a pending clear blocks acceptance.
    always_comb begin
        ready_s   = 1'b0;
        xfer_s    = 1'b0;
        newline_s = 1'b0;
        if ((state_r == IDLE) && !clear) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        xfer_s    = ch.char_valid && ready_s;
        newline_s = (ch.char_data == NEWLINE);
    end

    assign ch.char_ready = ready_s;

    // Pacing FSM: after every accepted character, stall for HOLD_CYCLES cycles.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_r    <= IDLE;
            hold_cnt_r <= 16'd0;
            busy_r     <= 1'b0;
        end else if (clear) begin
            state_r    <= IDLE;
            hold_cnt_r <= 16'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && HOLD_EN) begin
                        state_r    <= HOLD;
                        hold_cnt_r <= HOLD_LOAD;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        hold_cnt_r <= 16'd0;
                        busy_r     <= 1'b0;
                    end
                end
                HOLD: begin
                    // The count-0 cycle is still part of the hold, giving exactly HOLD_CYCLES stalled cycles.
                    if (hold_cnt_r == 16'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 16'd1;
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= 16'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Display buffer and non-blank character count.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= 8'd0;
            end
            count_r <= 3'd0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= 8'd0;
            end
            count_r <= 3'd0;
        end else if (xfer_s) begin
            if (newline_s) begin
                for (int i = 0; i < 4; i++) begin
                    slot_r[i] <= 8'd0;
                end
                count_r <= 3'd0;
            end else begin
                slot_r[0] <= slot_r[1];
                slot_r[1] <= slot_r[2];
                slot_r[2] <= slot_r[3];
                slot_r[3] <= ch.char_data;
                count_r   <= sat_inc(count_r);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign outputs_o  = {pack_slot(slot_r[0]), pack_slot(slot_r[1]),
                         pack_slot(slot_r[2]), pack_slot(slot_r[3])};
    assign char_count = count_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_sevenseg_text_writer.sv
// Bench for sevenseg_text_writer: three instances (hold 0, 3, 1000) driven by directed and random
// stimulus and checked every cycle against a slot-array/remaining-stall reference model.
module tb_sevenseg_text_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic rstn2;

    logic       v [3];
    logic [7:0] d [3];
    logic       c [3];

    logic [127:0] out_w  [3];
    logic [2:0]   cnt_w  [3];
    logic         busy_w [3];
    logic         rdy_w  [3];

    sevenseg_text_writer_if bus0 ();
    sevenseg_text_writer_if bus1 ();
    sevenseg_text_writer_if bus2 ();

    assign bus0.char_valid = v[0];
    assign bus0.char_data  = d[0];
    assign bus1.char_valid = v[1];
    assign bus1.char_data  = d[1];
    assign bus2.char_valid = v[2];
    assign bus2.char_data  = d[2];
    assign rdy_w[0] = bus0.char_ready;
    assign rdy_w[1] = bus1.char_ready;
    assign rdy_w[2] = bus2.char_ready;

    sevenseg_text_writer #(.HOLD_CYCLES(0)) dut0 (
        .system1000(clk), .system1000_rstn(rstn), .ch(bus0.slave), .clear(c[0]),
        .outputs_o(out_w[0]), .char_count(cnt_w[0]), .busy(busy_w[0]));
    sevenseg_text_writer #(.HOLD_CYCLES(3)) dut1 (
        .system1000(clk), .system1000_rstn(rstn), .ch(bus1.slave), .clear(c[1]),
        .outputs_o(out_w[1]), .char_count(cnt_w[1]), .busy(busy_w[1]));
    sevenseg_text_writer #(.HOLD_CYCLES(1000)) dut2 (
        .system1000(clk), .system1000_rstn(rstn2), .ch(bus2.slave), .clear(c[2]),
        .outputs_o(out_w[2]), .char_count(cnt_w[2]), .busy(busy_w[2]));

    // Reference model: visible characters left to right, count, and stalled cycles still to come.
    int           hold_len [3] = '{0, 3, 1000};
    byte unsigned mbuf  [3][4];
    int           mcnt  [3];
    int           mhold [3];
    bit           rdy_seen [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset(input int k);
        for (int i = 0; i < 4; i++) mbuf[k][i] = 8'd0;
        mcnt[k]  = 0;
        mhold[k] = 0;
    endfunction

    function automatic bit m_ready(input int k);
        return (mhold[k] == 0) && !c[k];
    endfunction

    function automatic void m_step(input int k);
        if (c[k]) begin
            m_reset(k);
        end else if (v[k] && m_ready(k)) begin
            if (d[k] == 8'h0A) begin
                for (int i = 0; i < 4; i++) mbuf[k][i] = 8'd0;
                mcnt[k] = 0;
            end else begin
                for (int i = 0; i < 3; i++) mbuf[k][i] = mbuf[k][i+1];
                mbuf[k][3] = d[k];
                mcnt[k] = (mcnt[k] < 4) ? mcnt[k] + 1 : 4;
            end
            mhold[k] = hold_len[k];
        end else if (mhold[k] > 0) begin
            mhold[k] = mhold[k] - 1;
        end
    endfunction

    function automatic logic [127:0] m_out(input int k);
        return {24'd0, mbuf[k][0], 24'd0, mbuf[k][1], 24'd0, mbuf[k][2], 24'd0, mbuf[k][3]};
    endfunction

    // One clock: ready checked before the edge, registered outputs just after it.
    task automatic tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy_seen[k] = rdy_w[k];
            check_val($sformatf("ready%0d", k), rdy_w[k], m_ready(k));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k);
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("out%0d", k),   out_w[k],  m_out(k));
            check_val($sformatf("count%0d", k), cnt_w[k],  mcnt[k]);
            check_val($sformatf("busy%0d", k),  busy_w[k], mhold[k] > 0);
        end
    endtask

    // Present a character until the DUT takes it; returns the accepting cycle.
    task automatic send(input int k, input logic [7:0] ch, output int t_acc);
        int guard;
        guard = 0;
        v[k] = 1'b1;
        d[k] = ch;
        do begin
            tick();
            guard++;
        end while (!rdy_seen[k] && guard < 2000);
        if (!rdy_seen[k]) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout%0d: no acceptance within %0d cycles", k, guard);
        end
        t_acc = cyc;
        v[k] = 1'b0;
    endtask

    initial begin
        int    ta, tb, tmp;
        string s;
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; d[k] = 8'd0; c[k] = 1'b0;
            m_reset(k);
        end
        rstn = 1'b1;
        rstn2 = 1'b1;
        #2;
        rstn = 1'b0;
        rstn2 = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("rst_out%0d", k),  out_w[k],  128'd0);
            check_val($sformatf("rst_cnt%0d", k),  cnt_w[k],  3'd0);
            check_val($sformatf("rst_busy%0d", k), busy_w[k], 1'b0);
        end
        @(negedge clk);
        rstn = 1'b1;
        rstn2 = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with no hold
        s = "hello";
        for (int i = 0; i < s.len(); i++) send(0, s[i], tmp);
        check_val("hello_out", out_w[0], {32'd101, 32'd108, 32'd108, 32'd111});
        check_val("hello_cnt", cnt_w[0], 3'd4);

        s = "_dlrow";
        for (int i = 0; i < s.len(); i++) send(0, s[i], tmp);
        check_val("dlrow_out", out_w[0], {32'd108, 32'd114, 32'd111, 32'd119});
        check_val("dlrow_cnt", cnt_w[0], 3'd4);

        send(0, "w", tmp);
        send(0, "o", tmp);
        send(0, 8'h0A, tmp);
        check_val("nl_out", out_w[0], 128'd0);
        check_val("nl_cnt", cnt_w[0], 3'd0);
        send(0, "!", tmp);
        check_val("bang_slot3", out_w[0][31:0], 32'd33);
        check_val("bang_cnt", cnt_w[0], 3'd1);

        // Clear wins over a same-cycle character
        c[0] = 1'b1; v[0] = 1'b1; d[0] = "x";
        tick();
        c[0] = 1'b0; v[0] = 1'b0;
        check_val("clrx_out", out_w[0], 128'd0);
        tick();
        check_val("clrx_ready", rdy_seen[0], 1'b1);

        // Held valid across a 3-cycle hold
        send(1, "a", ta);
        send(1, "b", tb);
        check_val("ab_gap", tb - ta, 4);
        check_val("ab_slot3", out_w[1][31:0], 32'd98);
        check_val("ab_slot2", out_w[1][63:32], 32'd97);
        repeat (4) tick();

        // Clear aborts a hold
        send(1, "z", tmp);
        c[1] = 1'b1;
        tick();
        c[1] = 1'b0;
        tick();
        check_val("clrhold_ready", rdy_seen[1], 1'b1);

        // Random traffic; an unaccepted character stays stable until taken
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                if (!(v[k] && !rdy_seen[k])) begin
                    v[k] = ($urandom_range(0, 2) != 0);
                    d[k] = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
                end
                c[k] = ($urandom_range(0, 19) == 0);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0;
            c[k] = 1'b0;
        end
        repeat (5) tick();

        // Asynchronous reset in the middle of a long hold
        send(2, "q", tmp);
        repeat (10) tick();
        check_val("hold_busy", busy_w[2], 1'b1);
        #2;
        rstn2 = 1'b0;
        #1;
        m_reset(2);
        check_val("arst_out",  out_w[2],  128'd0);
        check_val("arst_busy", busy_w[2], 1'b0);
        check_val("arst_cnt",  cnt_w[2],  3'd0);
        @(negedge clk);
        rstn2 = 1'b1;
        #1;
        check_val("arst_ready", rdy_w[2], 1'b1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k);
        #1;
        send(2, "k", tmp);
        check_val("arst_slot3", out_w[2][31:0], 32'd107);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
